// File: rtl/dircc_msg_pkg.sv
// rtl/dircc_msg_pkg.sv - shared FSM state type and bus widths for the message ring writer
package dircc_msg_pkg;

    localparam int FLIT_W = 16;
    localparam int MEM_AW = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_HEADER  = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

endpackage

// File: rtl/dircc_msg_ring_writer_if.sv
// rtl/dircc_msg_ring_writer_if.sv - router flit stream in, 16-bit processing-memory write port out
interface dircc_msg_ring_writer_if;
    import dircc_msg_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;

    logic [MEM_AW-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [FLIT_W-1:0] mem_writedata;
    logic [1:0]        mem_byteenable;
    logic              mem_clken;

    modport master (
        output in_valid, in_data, in_sop, in_eop,
        input  in_ready,
        input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop,
        output in_ready,
        output mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken
    );

endinterface

// File: rtl/dircc_ring_space.sv
// rtl/dircc_ring_space.sv - free-space test: is there room for one worst-case packet plus header
module dircc_ring_space #(
    parameter int RING_WORDS    = 2048,
    parameter int MAX_PKT_WORDS = 32
) (
    input  logic [$clog2(RING_WORDS)-1:0] i_wr_ptr,
    input  logic [$clog2(RING_WORDS)-1:0] i_rd_ptr,
    output logic                          o_space_ok
);

    localparam int PW = $clog2(RING_WORDS);

    logic [PW-1:0] w_used;
    logic [PW-1:0] w_free;

    // Pointer subtraction wraps naturally because the ring size is a power of two.
    assign w_used     = i_wr_ptr - i_rd_ptr;
    assign w_free     = PW'(RING_WORDS - 1) - w_used;
    assign o_space_ok = (32'(w_free) >= MAX_PKT_WORDS + 1);

endmodule

// File: rtl/dircc_msg_ring_writer.sv
// rtl/dircc_msg_ring_writer.sv - writes router packets into a CPU ring, header committed last
module dircc_msg_ring_writer
    import dircc_msg_pkg::*;
#(
    parameter logic [MEM_AW-1:0] BASE_ADDR     = 14'd12288,
    parameter int                RING_WORDS    = 2048,
    parameter int                MAX_PKT_WORDS = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    dircc_msg_ring_writer_if.slave        bus,
    input  logic [$clog2(RING_WORDS)-1:0] cpu_rd_ptr,
    output logic [$clog2(RING_WORDS)-1:0] wr_ptr,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   drop_count,
    output logic                          irq,
    input  logic                          irq_ack
);

    localparam int              PW      = $clog2(RING_WORDS);
    localparam int              LW      = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [LW-1:0]   LEN_MAX = LW'(MAX_PKT_WORDS);

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_wr_ptr;
    logic [LW-1:0]     r_len, w_len_nxt;
    logic [15:0]       r_pkt_count, r_drop_count;
    logic              r_irq;

    logic              w_space_ok, w_ready, w_accept;
    logic              w_wr_en, w_commit, w_drop;
    logic [PW-1:0]     w_wr_off;
    logic [FLIT_W-1:0] w_wr_data;

    dircc_ring_space #(
        .RING_WORDS    (RING_WORDS),
        .MAX_PKT_WORDS (MAX_PKT_WORDS)
    ) u_space (
        .i_wr_ptr   (r_wr_ptr),
        .i_rd_ptr   (cpu_rd_ptr),
        .o_space_ok (w_space_ok)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_ready     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_off    = r_wr_ptr + PW'(1);
        w_wr_data   = bus.in_data;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE:   w_ready = w_space_ok;
                ST_HEADER: w_ready = 1'b0;
                default:   w_ready = 1'b1;
            endcase
        end
        w_accept = bus.in_valid && w_ready;

        case (r_state)
            ST_IDLE, ST_PAYLOAD: begin
                if (w_accept && bus.in_sop) begin
                    // A SOP always starts a fresh packet; a partial one in flight is abandoned.
                    w_drop      = (r_state == ST_PAYLOAD);
                    w_wr_en     = 1'b1;
                    w_len_nxt   = LW'(1);
                    w_state_nxt = bus.in_eop ? ST_HEADER : ST_PAYLOAD;
                end else if (w_accept && r_state == ST_IDLE) begin
                    w_drop      = bus.in_eop;
                    w_state_nxt = bus.in_eop ? ST_IDLE : ST_DROP;
                end else if (w_accept) begin
                    if (r_len == LEN_MAX) begin
                        w_drop      = bus.in_eop;
                        w_state_nxt = bus.in_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_wr_off  = r_wr_ptr + PW'(1) + PW'(r_len);
                        w_len_nxt = r_len + LW'(1);
                        if (bus.in_eop) w_state_nxt = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                w_wr_en     = 1'b1;
                w_wr_off    = r_wr_ptr;
                w_wr_data   = FLIT_W'(r_len);
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                if (w_accept && bus.in_eop) begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_len        <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            if (w_commit) begin
                r_wr_ptr    <= r_wr_ptr + PW'(r_len) + PW'(1);
                r_pkt_count <= r_pkt_count + 16'd1;
            end
            if (w_drop) r_drop_count <= r_drop_count + 16'd1;
            // A commit wins over a coincident acknowledge so no packet goes unsignalled.
            if (w_commit)     r_irq <= 1'b1;
            else if (irq_ack) r_irq <= 1'b0;
        end
    end

    assign bus.in_ready       = w_ready;
    assign bus.mem_chipselect = w_wr_en && !reset;
    assign bus.mem_write      = w_wr_en && !reset;
    assign bus.mem_address    = BASE_ADDR + MEM_AW'(w_wr_off);
    assign bus.mem_writedata  = w_wr_data;
    assign bus.mem_byteenable = 2'b11;
    assign bus.mem_clken      = 1'b1;

    assign wr_ptr     = r_wr_ptr;
    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;
    assign irq        = r_irq;

endmodule

// File: tb/tb_dircc_msg_ring_writer.sv
// tb/tb_dircc_msg_ring_writer.sv - randomized packet traffic against a packet-level ring model
module tb_dircc_msg_ring_writer;

    localparam int RW   = 2048;
    localparam int MAXW = 32;
    localparam int BASE = 12288;
    localparam int M_IDLE = 0, M_COLL = 1, M_COMMIT = 2, M_DISC = 3;

    typedef struct {
        logic [15:0] d;
        bit          sop;
        bit          eop;
    } flit_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] cpu_rd_ptr;
    logic [10:0] wr_ptr;
    logic [15:0] pkt_count, drop_count;
    logic        irq, irq_ack;

    dircc_msg_ring_writer_if bus ();

    dircc_msg_ring_writer #(
        .BASE_ADDR     (14'd12288),
        .RING_WORDS    (RW),
        .MAX_PKT_WORDS (MAXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_rd_ptr (cpu_rd_ptr),
        .wr_ptr     (wr_ptr),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .irq        (irq),
        .irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    bit          t_reset, t_valid, t_sop, t_eop, t_ack;
    logic [15:0] t_data;
    int          t_rd;

    int m_wp, m_pkt, m_drop, m_mode;
    bit m_irq;
    int m_q[$];

    int    log_addr[$], log_data[$];
    bit    last_acc;
    flit_t src[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic start_packet(input int d, input bit eop, output int wa, output int wd);
        m_q.delete();
        m_q.push_back(d);
        wa = BASE + (m_wp + 1) % RW;
        wd = d;
        m_mode = eop ? M_COMMIT : M_COLL;
    endtask

    task automatic step();
        int free, len, exp_addr, exp_data;
        bit exp_ready, exp_wr, acc, commit;
        @(negedge clk);
        reset         = t_reset;
        bus.in_valid  = t_valid;
        bus.in_data   = t_data;
        bus.in_sop    = t_sop;
        bus.in_eop    = t_eop;
        cpu_rd_ptr    = t_rd[10:0];
        irq_ack       = t_ack;
        #1;
        free = RW - 1 - ((m_wp - t_rd) & (RW - 1));
        if (t_reset || m_mode == M_COMMIT) exp_ready = 0;
        else if (m_mode == M_IDLE)         exp_ready = (free >= MAXW + 1);
        else                               exp_ready = 1;
        acc = t_valid && exp_ready;
        len = m_q.size();
        exp_wr = 0; exp_addr = 0; exp_data = 0; commit = 0;
        if (!t_reset) begin
            check("wr_ptr", wr_ptr, m_wp);
            check("pkt_count", pkt_count, m_pkt & 16'hFFFF);
            check("drop_count", drop_count, m_drop & 16'hFFFF);
            check("irq", irq, m_irq);
            if (m_mode == M_COMMIT) begin
                exp_wr = 1; exp_addr = BASE + m_wp; exp_data = len;
                m_wp = (m_wp + len + 1) % RW;
                m_pkt++; commit = 1; m_mode = M_IDLE;
            end else if (acc && t_sop && (m_mode == M_IDLE || m_mode == M_COLL)) begin
                if (m_mode == M_COLL) m_drop++;
                exp_wr = 1;
                start_packet(t_data, t_eop, exp_addr, exp_data);
            end else if (acc && m_mode == M_IDLE) begin
                if (t_eop) m_drop++; else m_mode = M_DISC;
            end else if (acc && m_mode == M_COLL) begin
                if (len == MAXW) begin
                    if (t_eop) begin m_drop++; m_mode = M_IDLE; end
                    else m_mode = M_DISC;
                end else begin
                    exp_wr = 1; exp_addr = BASE + (m_wp + 1 + len) % RW; exp_data = t_data;
                    m_q.push_back(t_data);
                    if (t_eop) m_mode = M_COMMIT;
                end
            end else if (acc && m_mode == M_DISC && t_eop) begin
                m_drop++; m_mode = M_IDLE;
            end
            if (commit)     m_irq = 1;
            else if (t_ack) m_irq = 0;
        end
        check("in_ready", bus.in_ready, exp_ready);
        check("mem_chipselect", bus.mem_chipselect, exp_wr);
        check("mem_write", bus.mem_write, exp_wr);
        check("mem_byteenable", bus.mem_byteenable, 2'b11);
        check("mem_clken", bus.mem_clken, 1);
        if (exp_wr) begin
            check("mem_address", bus.mem_address, exp_addr);
            check("mem_writedata", bus.mem_writedata, exp_data);
        end
        if (bus.mem_chipselect) begin
            log_addr.push_back(int'(bus.mem_address));
            log_data.push_back(int'(bus.mem_writedata));
        end
        last_acc = bus.in_valid && bus.in_ready;
        if (t_reset) begin
            m_wp = 0; m_pkt = 0; m_drop = 0; m_irq = 0; m_mode = M_IDLE; m_q.delete();
        end
    endtask

    task automatic idle(input int n);
        t_valid = 0; t_sop = 0; t_eop = 0;
        repeat (n) step();
    endtask

    task automatic send_flit(input logic [15:0] d, input bit sop, input bit eop);
        bit done = 0;
        t_valid = 1; t_data = d; t_sop = sop; t_eop = eop;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = last_acc;
        end
        if (!done) check("send_timeout", 0, 1);
        t_valid = 0;
    endtask

    task automatic send_pkt(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) send_flit(base + 16'(i), i == 0, i == n - 1);
    endtask

    task automatic gen_traffic();
        int r = $urandom_range(9);
        int n;
        flit_t f;
        if (r == 0) begin
            n = $urandom_range(3, 1);
            for (int i = 0; i < n; i++) begin
                f.d = 16'($urandom); f.sop = 0; f.eop = (i == n - 1); src.push_back(f);
            end
        end else if (r == 1) begin
            n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++) begin
                f.d = 16'($urandom); f.sop = (i == 0); f.eop = 0; src.push_back(f);
            end
        end else begin
            n = $urandom_range(40, 1);
            for (int i = 0; i < n; i++) begin
                f.d = 16'($urandom); f.sop = (i == 0); f.eop = (i == n - 1); src.push_back(f);
            end
        end
    endtask

    task automatic random_phase(input int cycles);
        int used;
        for (int c = 0; c < cycles; c++) begin
            if (src.size() == 0) gen_traffic();
            t_valid = ($urandom_range(3) != 0);
            t_data  = src[0].d; t_sop = src[0].sop; t_eop = src[0].eop;
            t_ack   = ($urandom_range(5) == 0);
            if ($urandom_range(7) == 0) begin
                used = (m_wp - t_rd) & (RW - 1);
                t_rd = (t_rd + int'($urandom_range(used))) & (RW - 1);
            end
            step();
            if (last_acc) void'(src.pop_front());
        end
        t_ack = 0;
    endtask

    int d0, p0, w0;
    bit hit;

    initial begin
        t_reset = 1; t_valid = 0; t_sop = 0; t_eop = 0; t_ack = 0; t_data = 0; t_rd = 0;
        m_wp = 0; m_pkt = 0; m_drop = 0; m_irq = 0; m_mode = M_IDLE;
        step(); step();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_chipselect", bus.mem_chipselect, 0);
        t_reset = 0;
        step();
        check("rst_wr_ptr", wr_ptr, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_irq", irq, 0);

        // Three-flit packet at wr_ptr 0.
        log_addr.delete(); log_data.delete();
        send_flit(16'hA1, 1, 0); send_flit(16'hA2, 0, 0); send_flit(16'hA3, 0, 1);
        idle(2);
        check("p3_nwrites", log_addr.size(), 4);
        check("p3_addr0", log_addr[0], 12289); check("p3_data0", log_data[0], 16'hA1);
        check("p3_addr1", log_addr[1], 12290); check("p3_data1", log_data[1], 16'hA2);
        check("p3_addr2", log_addr[2], 12291); check("p3_data2", log_data[2], 16'hA3);
        check("p3_hdr_addr", log_addr[3], 12288); check("p3_hdr_len", log_data[3], 3);
        check("p3_wr_ptr", wr_ptr, 4); check("p3_pkt_count", pkt_count, 1); check("p3_irq", irq, 1);

        // Walk wr_ptr up to 2046 with the consumer keeping pace.
        t_ack = 1; idle(1); t_ack = 0;
        for (int k = 0; k < 61; k++) begin
            t_rd = m_wp; send_pkt(32, 16'(k * 64)); idle(1);
        end
        t_rd = m_wp; send_pkt(28, 16'h7700); idle(2);
        check("walk_wr_ptr", wr_ptr, 2046);

        // Packet straddling the ring end.
        log_addr.delete(); log_data.delete();
        t_rd = 2046; send_pkt(2, 16'hB0); idle(2);
        check("wrap_addr0", log_addr[0], 14335);
        check("wrap_addr1", log_addr[1], 12288);
        check("wrap_hdr_addr", log_addr[2], 14334); check("wrap_hdr_len", log_data[2], 2);
        check("wrap_wr_ptr", wr_ptr, 1);

        // Exactly 31 words free blocks a new packet; freeing the ring reopens it.
        t_rd = 33; idle(1);
        check("full_in_ready", bus.in_ready, 0);
        t_rd = 1; idle(1);
        check("freed_in_ready", bus.in_ready, 1);

        // Oversize packet is truncated and dropped, then traffic resumes.
        d0 = drop_count; p0 = pkt_count; w0 = wr_ptr;
        log_addr.delete(); log_data.delete();
        send_pkt(40, 16'hC00); idle(2);
        check("big_nwrites", log_addr.size(), 32);
        check("big_drop", drop_count, 16'(d0 + 1));
        check("big_wr_ptr", wr_ptr, w0); check("big_pkt", pkt_count, p0);
        send_pkt(4, 16'hD0); idle(2);
        check("after_big_pkt", pkt_count, 16'(p0 + 1));
        check("after_big_wr_ptr", wr_ptr, (w0 + 5) % RW);

        // SOP arriving mid-packet abandons the partial packet.
        d0 = drop_count; p0 = pkt_count; w0 = wr_ptr;
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 5; i++) send_flit(16'h50 + 16'(i), i == 0, 0);
        send_pkt(3, 16'hE0); idle(2);
        check("abandon_drop", drop_count, 16'(d0 + 1));
        check("abandon_pkt", pkt_count, 16'(p0 + 1));
        check("abandon_nwrites", log_addr.size(), 9);
        check("abandon_first_new", log_data[5], 16'hE0);
        check("abandon_hdr_addr", log_addr[8], BASE + w0);
        check("abandon_hdr_len", log_data[8], 3);
        check("abandon_wr_ptr", wr_ptr, (w0 + 4) % RW);

        // Acknowledge coincident with commit keeps irq set.
        t_ack = 1; idle(1); t_ack = 0; idle(1);
        check("ack_clears_irq", irq, 0);
        t_ack = 1; send_pkt(2, 16'hF0); idle(1); t_ack = 0; idle(1);
        check("ack_with_commit_irq", irq, 1);
        t_ack = 1; idle(1); t_ack = 0; idle(1);
        check("ack_after_commit_irq", irq, 0);

        random_phase(6000);

        // Reset while a packet is being collected.
        hit = 0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            if (m_mode == M_COLL) hit = 1;
            else random_phase(1);
        end
        check("reached_mid_packet", hit, 1);
        t_reset = 1; t_valid = 0; step(); t_reset = 0; t_rd = 0; src.delete();
        idle(1);
        check("midrst_wr_ptr", wr_ptr, 0);
        check("midrst_pkt", pkt_count, 0);
        check("midrst_drop", drop_count, 0);

        random_phase(3000);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dircc_msg_ring_writer.md
DIRCC_MSG_RING_WRITER -- requirements
Module: dircc_msg_ring_writer

Interface
REQ-001 Parameter BASE_ADDR, default 14'd12288, ring base word address on the 16-bit memory port.
REQ-002 Parameter RING_WORDS, default 2048, ring size in 16-bit words; SHALL be a power of two.
REQ-003 Parameter MAX_PKT_WORDS, default 32, maximum payload words per packet.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  stream handshake from router; transfer when both high.
REQ-007 in_data  in  16  flit payload.
REQ-008 in_sop / in_eop  in  1 / 1  first / last flit of packet.
REQ-009 mem_address  out  14  word address to processing-memory 16-bit port.
REQ-010 mem_chipselect, mem_write  out  1  both high for one cycle per write.
REQ-011 mem_writedata  out  16; mem_byteenable  out  2, constant 2'b11; mem_clken  out  1, constant 1.
REQ-012 cpu_rd_ptr  in  log2(RING_WORDS)  consumer offset, written by CPU.
REQ-013 wr_ptr  out  log2(RING_WORDS)  committed producer offset.
REQ-014 pkt_count  out  16, drop_count  out  16  committed and dropped packet counters, wrap at 2^16.
REQ-015 irq  out  1; irq_ack  in  1  level interrupt and single-cycle clear.

Function
REQ-016 Ring slot per packet: header word (payload length) at wr_ptr, payload at wr_ptr+1 ..; all offsets modulo RING_WORDS; mem_address = BASE_ADDR + offset.
REQ-017 FSM states IDLE, PAYLOAD, HEADER, DROP.
REQ-018 free = RING_WORDS-1-((wr_ptr-cpu_rd_ptr) mod RING_WORDS); space_ok = free >= MAX_PKT_WORDS+1.
REQ-019 IDLE: in_ready = space_ok; accepted SOP flit written at wr_ptr+1, len=1; next state HEADER if in_eop else PAYLOAD.
REQ-020 IDLE: accepted non-SOP flit discarded, no memory write, drop_count+1 on its eop (or at once if eop set).
REQ-021 PAYLOAD: in_ready=1; each accepted flit written at wr_ptr+1+len, len+1, same cycle as acceptance (zero-latency, no write backpressure).
REQ-022 PAYLOAD: flit with len==MAX_PKT_WORDS -> not written, go DROP (or straight to IDLE with drop_count+1 if in_eop).
REQ-023 PAYLOAD: SOP flit -> partial packet abandoned uncommitted, drop_count+1, flit treated as new SOP per REQ-019.
REQ-024 PAYLOAD eop -> HEADER. HEADER: in_ready=0; write len at wr_ptr; same cycle wr_ptr <= wr_ptr+len+1, pkt_count+1, irq set; -> IDLE.
REQ-025 DROP: in_ready=1, flits discarded until eop; then drop_count+1 -> IDLE.
REQ-026 wr_ptr changes only in HEADER; CPU never sees partial packet.
REQ-027 irq set on commit, cleared by irq_ack; simultaneous set and ack -> irq stays 1.
REQ-028 Outside writes mem_chipselect=mem_write=0; at most one write per cycle.

Reset
REQ-029 Reset: state IDLE, wr_ptr=0, len=0, pkt_count=0, drop_count=0, irq=0, in_ready=0 during reset cycle, mem_chipselect=mem_write=0.
REQ-030 Reset mid-packet abandons packet; no commit, no drop count.

Structure
REQ-031 Shared package dircc_msg_pkg holds FSM state enum, flit width (16), memory address width (14).
REQ-032 Sub-module dircc_ring_space computes free/space_ok combinationally from wr_ptr, cpu_rd_ptr.

Verification
REQ-033 3-flit packet 0xA1,0xA2,0xA3 (sop on first, eop on last), wr_ptr=0 -> writes 12289..12291 data, then 12288=3; wr_ptr=4, pkt_count=1, irq=1.
REQ-034 wr_ptr=2046, 2-flit packet -> payload at 12288+2047, 12288+0, header at 12288+2046; wr_ptr=1.
REQ-035 cpu_rd_ptr=wr_ptr+32 (free=31) -> in_ready=0 in IDLE; move cpu_rd_ptr to wr_ptr -> in_ready=1 next cycle.
REQ-036 40-flit packet -> 32 payload writes, no header write, wr_ptr unchanged, drop_count=1, next packet accepted normally.
REQ-037 SOP in PAYLOAD after 5 flits -> drop_count=1, new packet committed with correct len, old data not committed.
REQ-038 irq_ack asserted same cycle as commit -> irq=1; irq_ack next cycle -> irq=0.
